// File: rtl/multibyte_add_seq.sv
// Byte-serial adder/sequencer: streams BYTES-wide operands one byte per cycle through one 8-bit adder.
// Optional subtract support is enabled by defining MULTIBYTE_ADD_SUB_EN.
`timescale 1ns/1ps

module simple_8bit_adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       c_in,
    output logic [7:0] sum,
    output logic       c_out
);
    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {8'b0, c_in};
endmodule

module multibyte_add_seq #(
    parameter int BYTES = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*BYTES-1:0] a,
    input  logic [8*BYTES-1:0] b,
    input  logic               c_in,
`ifdef MULTIBYTE_ADD_SUB_EN
    input  logic               sub,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*BYTES-1:0] sum,
    output logic               c_out,
    output logic               zero,
    output logic               ovf
);
    localparam int W  = 8 * BYTES;
    localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_next;
    logic [W-1:0]    a_reg, b_reg, sum_next;
    logic [W-1:0]    b_eff;
    logic            c_in_eff;
    logic [IW-1:0]   idx;
    logic            carry;
    logic [7:0]      add_sum;
    logic            add_cout;
    logic            last_byte;

`ifdef MULTIBYTE_ADD_SUB_EN
    // Two's-complement subtract: invert B and force the initial carry.
    assign b_eff    = sub ? ~b : b;
    assign c_in_eff = sub ? 1'b1 : c_in;
`else
    assign b_eff    = b;
    assign c_in_eff = c_in;
`endif

    assign last_byte = (idx == LAST_IDX);

    simple_8bit_adder u_adder (
        .a     (a_reg[8*idx +: 8]),
        .b     (b_reg[8*idx +: 8]),
        .c_in  (carry),
        .sum   (add_sum),
        .c_out (add_cout)
    );

    // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        sum_next = sum;
        sum_next[8*idx +: 8] = add_sum;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                if (last_byte) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            idx   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            c_out <= 1'b0;
            zero  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= b_eff;
                        carry <= c_in_eff;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    sum   <= sum_next;
                    carry <= add_cout;
                    if (last_byte) begin
                        // Flags are computed from the completed result so they are stable in DONE.
                        c_out <= add_cout;
                        zero  <= ~|sum_next;
                        ovf   <= (a_reg[W-1] == b_reg[W-1]) & (sum_next[W-1] != a_reg[W-1]);
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
